// File: rtl/tradeoff_job_scheduler_if.sv
// Host-side job/result bundle for the shared search-core scheduler.
// The host drives jobs and consumes results; the scheduler grants and answers.
interface tradeoff_job_scheduler_if #(
    parameter int W_BITS  = 69,
    parameter int N_BITS  = 53,
    parameter int NUM_REQ = 4,
    parameter int ID_BITS = 2
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*W_BITS-1:0] req_w;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_BITS-1:0]        rsp_id;
    logic [N_BITS-1:0]         rsp_n;
    logic                      rsp_timeout;

    modport master (
        output req_valid, req_w, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_n, rsp_timeout
    );

    modport slave (
        input  req_valid, req_w, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_n, rsp_timeout
    );
endinterface

// File: rtl/tradeoff_job_scheduler.sv
// Round-robin job scheduler in front of one shared search core.
// One job in flight: reset core, run until found or timeout, settle, respond.
module tradeoff_job_scheduler #(
    parameter int W_BITS      = 69,
    parameter int N_BITS      = 53,
    parameter int NUM_REQ     = 4,
    parameter int ID_BITS     = 2,
    parameter int RST_CYC     = 2,
    parameter int SETTLE_CYC  = 1,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    tradeoff_job_scheduler_if.slave bus,
    output logic                  core_rst_n,
    output logic [W_BITS-1:0]     core_w,
    input  logic                  core_found,
    input  logic [N_BITS-1:0]     core_n
);
    typedef enum logic [2:0] {
        IDLE,
        CRST,
        RUN,
        SETTLE,
        RESP
    } state_t;

    localparam int CNT_BITS = $clog2(TIMEOUT_CYC + RST_CYC + SETTLE_CYC + 1);
    localparam logic [CNT_BITS-1:0] RST_LAST = CNT_BITS'(RST_CYC - 1);
    localparam logic [CNT_BITS-1:0] RUN_LAST = CNT_BITS'(TIMEOUT_CYC - 1);
    localparam logic [CNT_BITS-1:0] SET_LAST =
        CNT_BITS'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
    localparam logic [ID_BITS-1:0] ID_LAST = ID_BITS'(NUM_REQ - 1);
    localparam logic [ID_BITS:0]   NREQ    = (ID_BITS + 1)'(NUM_REQ);

    state_t               state;
    logic [CNT_BITS-1:0]  cnt;
    logic [ID_BITS-1:0]   rr_ptr;
    logic [NUM_REQ-1:0]   grant;
    logic [ID_BITS-1:0]   gnt_id;
    logic                 hit;
    logic [ID_BITS:0]     sum;
    logic [ID_BITS-1:0]   idx;

    // Scan from rr_ptr upward with wrap; first valid requester wins.
    always_comb begin
        grant  = '0;
        gnt_id = '0;
        hit    = 1'b0;
        sum    = '0;
        idx    = '0;
        if (state == IDLE) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                sum = {1'b0, rr_ptr} + (ID_BITS + 1)'(k);
                if (sum >= NREQ) begin
                    sum = sum - NREQ;
                end
                idx = sum[ID_BITS-1:0];
                if (!hit && bus.req_valid[idx]) begin
                    hit        = 1'b1;
                    grant[idx] = 1'b1;
                    gnt_id     = idx;
                end
            end
        end
    end

    assign bus.req_ready = grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            rr_ptr          <= '0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_id      <= '0;
            bus.rsp_n       <= '0;
            bus.rsp_timeout <= 1'b0;
            core_w          <= '0;
            core_rst_n      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    core_rst_n <= 1'b1;
                    if (hit) begin
                        core_w     <= bus.req_w[gnt_id*W_BITS +: W_BITS];
                        bus.rsp_id <= gnt_id;
                        rr_ptr     <= (gnt_id == ID_LAST) ? '0
                                                          : gnt_id + ID_BITS'(1);
                        cnt        <= '0;
                        core_rst_n <= 1'b0;
                        state      <= CRST;
                    end
                end
                CRST: begin
                    if (cnt == RST_LAST) begin
                        cnt        <= '0;
                        core_rst_n <= 1'b1;
                        state      <= RUN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    // found is checked first so it beats a same-cycle timeout
                    if (core_found) begin
                        cnt <= '0;
                        if (SETTLE_CYC == 0) begin
                            bus.rsp_n       <= core_n;
                            bus.rsp_timeout <= 1'b0;
                            bus.rsp_valid   <= 1'b1;
                            state           <= RESP;
                        end else begin
                            state <= SETTLE;
                        end
                    end else if (cnt == RUN_LAST) begin
                        bus.rsp_n       <= '0;
                        bus.rsp_timeout <= 1'b1;
                        bus.rsp_valid   <= 1'b1;
                        state           <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt == SET_LAST) begin
                        bus.rsp_n       <= core_n;
                        bus.rsp_timeout <= 1'b0;
                        bus.rsp_valid   <= 1'b1;
                        state           <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tradeoff_job_scheduler.sv
// Directed bench for the job scheduler: a job-level model plus a small
// behavioural core that reports found a configurable number of cycles after release.
module tb_tradeoff_job_scheduler;
    localparam int W_BITS      = 69;
    localparam int N_BITS      = 53;
    localparam int NUM_REQ     = 4;
    localparam int ID_BITS     = 2;
    localparam int RST_CYC     = 2;
    localparam int SETTLE_CYC  = 1;
    localparam int TIMEOUT_CYC = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              core_rst_n;
    logic [W_BITS-1:0] core_w;
    logic              core_found = 1'b0;
    logic [N_BITS-1:0] core_n = '0;

    tradeoff_job_scheduler_if #(
        .W_BITS(W_BITS), .N_BITS(N_BITS), .NUM_REQ(NUM_REQ), .ID_BITS(ID_BITS)
    ) bus ();

    tradeoff_job_scheduler #(
        .W_BITS(W_BITS), .N_BITS(N_BITS), .NUM_REQ(NUM_REQ), .ID_BITS(ID_BITS),
        .RST_CYC(RST_CYC), .SETTLE_CYC(SETTLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .core_rst_n(core_rst_n),
        .core_w(core_w),
        .core_found(core_found),
        .core_n(core_n)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // per-requester job settings: found delay (0 = never) and result
    int                cfg_d [NUM_REQ];
    logic [N_BITS-1:0] cfg_n [NUM_REQ];

    // current job as seen by the model
    int                job_d = 0;
    logic [N_BITS-1:0] job_n = '0;
    logic              busy = 1'b0;
    int                ptr = 0;
    logic [ID_BITS-1:0] j_id;
    logic [W_BITS-1:0] j_w;
    int                lowcnt, runcnt;
    logic              seen;
    logic [ID_BITS-1:0] h_id;
    logic [N_BITS-1:0] h_n;
    logic              h_to;

    int acc_cnt = 0;
    int rsp_cnt = 0;
    int grant_log[$];
    int rsp_log[$];
    logic [N_BITS-1:0] last_n;
    logic              last_to;
    int                last_low, last_run;

    // behavioural core: found rises job_d cycles after core_rst_n releases
    int core_cyc = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!core_rst_n) begin
                core_cyc   = 0;
                core_found = 1'b0;
            end else begin
                core_cyc++;
                core_found = (job_d != 0) && (core_cyc >= job_d);
            end
            core_n = core_found ? job_n : 53'h0ab_cdef_0123;
        end
    end

    logic [NUM_REQ-1:0] exp_rdy;
    int                 g, pi;
    logic [N_BITS-1:0]  e_n;
    int                 e_run;

    always @(negedge clk) begin
        if (rst) begin
            busy = 1'b0;
            ptr  = 0;
            seen = 1'b0;
        end else begin
            exp_rdy = '0;
            g = -1;
            if (!busy) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    pi = (ptr + k) % NUM_REQ;
                    if (g < 0 && bus.req_valid[pi]) begin
                        g = pi;
                        exp_rdy[pi] = 1'b1;
                    end
                end
            end
            chk("req_ready", bus.req_ready, exp_rdy);
            if (!busy) begin
                chk("rsp_valid_idle", bus.rsp_valid, 1'b0);
                if (g >= 0) begin
                    busy   = 1'b1;
                    j_id   = ID_BITS'(g);
                    j_w    = bus.req_w[g*W_BITS +: W_BITS];
                    job_d  = cfg_d[g];
                    job_n  = cfg_n[g];
                    ptr    = (g + 1) % NUM_REQ;
                    lowcnt = 0;
                    runcnt = 0;
                    seen   = 1'b0;
                    acc_cnt++;
                    grant_log.push_back(g);
                end
            end else begin
                chk("core_w", core_w, j_w);
                if (!bus.rsp_valid) begin
                    if (!core_rst_n) begin
                        lowcnt++;
                    end else begin
                        runcnt++;
                        if (runcnt == 1) begin
                            last_low = lowcnt;
                            chk("crst_len", lowcnt, RST_CYC);
                        end
                    end
                end else begin
                    if (!seen) begin
                        seen  = 1'b1;
                        e_run = (job_d == 0) ? TIMEOUT_CYC : job_d + SETTLE_CYC;
                        e_n   = (job_d == 0) ? '0 : job_n;
                        chk("run_len", runcnt, e_run);
                        chk("rsp_id", bus.rsp_id, j_id);
                        chk("rsp_n", bus.rsp_n, e_n);
                        chk("rsp_timeout", bus.rsp_timeout, job_d == 0);
                        h_id     = bus.rsp_id;
                        h_n      = bus.rsp_n;
                        h_to     = bus.rsp_timeout;
                        last_n   = bus.rsp_n;
                        last_to  = bus.rsp_timeout;
                        last_run = runcnt;
                    end else begin
                        chk("rsp_hold", {bus.rsp_id, bus.rsp_n, bus.rsp_timeout},
                            {h_id, h_n, h_to});
                    end
                    if (bus.rsp_ready) begin
                        busy = 1'b0;
                        rsp_cnt++;
                        rsp_log.push_back(int'(bus.rsp_id));
                    end
                end
            end
        end
    end

    task automatic set_w(input int i, input logic [W_BITS-1:0] v);
        bus.req_w[i*W_BITS +: W_BITS] = v;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // hold mask valid until n jobs are accepted, then wait for n responses
    task automatic run(input logic [NUM_REQ-1:0] mask, input int n);
        int a0, r0, cyc;
        a0 = acc_cnt;
        r0 = rsp_cnt;
        cyc = 0;
        bus.req_valid = mask;
        while (rsp_cnt - r0 < n && cyc < 2000) begin
            tick(1);
            cyc++;
            if (acc_cnt - a0 >= n) bus.req_valid = '0;
        end
        bus.req_valid = '0;
        chk("run_done", rsp_cnt - r0 >= n, 1'b1);
    endtask

    int ord[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int gs, rs, a0, r0, cyc;

    initial begin
        bus.req_valid = '0;
        bus.req_w     = '0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            cfg_d[i] = 2 + i;
            cfg_n[i] = N_BITS'(100 + i);
            set_w(i, W_BITS'(1000 + i));
        end

        // reset values
        rst = 1'b1;
        tick(2);
        chk("rst_req_ready", bus.req_ready, '0);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_id", bus.rsp_id, '0);
        chk("rst_rsp_n", bus.rsp_n, '0);
        chk("rst_rsp_timeout", bus.rsp_timeout, 1'b0);
        chk("rst_core_w", core_w, '0);
        chk("rst_core_rst_n", core_rst_n, 1'b0);
        rst = 1'b0;

        // single job on requester 0
        cfg_d[0] = 3;
        cfg_n[0] = 53'd4503599627370495;
        set_w(0, 69'd12345);
        run(4'b0001, 1);
        chk("t2_id", rsp_log[rsp_log.size()-1], 0);
        chk("t2_n", last_n, 53'd4503599627370495);
        chk("t2_to", last_to, 1'b0);
        chk("t2_low", last_low, 2);
        set_w(0, W_BITS'(1000));

        // all four requesters valid for eight jobs, from a fresh pointer
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        gs = grant_log.size();
        rs = rsp_log.size();
        run(4'b1111, 8);
        for (int k = 0; k < 8; k++) begin
            chk("t3_grant", grant_log[gs+k], ord[k]);
            chk("t3_rsp_id", rsp_log[rs+k], ord[k]);
        end

        // core never finds: timeout, then a normal job restarts the core
        cfg_d[1] = 0;
        run(4'b0010, 1);
        chk("t4_to", last_to, 1'b1);
        chk("t4_n", last_n, '0);
        chk("t4_run", last_run, 16);
        cfg_d[2] = 4;
        cfg_n[2] = 53'h1_0000_0001;
        run(4'b0100, 1);
        chk("t4b_low", last_low, 2);
        chk("t4b_to", last_to, 1'b0);
        chk("t4b_n", last_n, 53'h1_0000_0001);

        // backpressure on the result
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b1000;
        cyc = 0;
        while (!bus.rsp_valid && cyc < 100) begin
            tick(1);
            cyc++;
        end
        chk("t5_rsp_seen", bus.rsp_valid, 1'b1);
        bus.req_valid = 4'b1001;
        a0 = acc_cnt;
        tick(10);
        chk("t5_no_grant", acc_cnt, a0);
        chk("t5_valid_held", bus.rsp_valid, 1'b1);
        r0 = rsp_cnt;
        bus.rsp_ready = 1'b1;
        tick(2);
        chk("t5_next_grant", acc_cnt, a0 + 1);
        chk("t5_next_id", grant_log[grant_log.size()-1], 0);
        bus.req_valid = '0;
        cyc = 0;
        while (rsp_cnt < r0 + 2 && cyc < 100) begin
            tick(1);
            cyc++;
        end
        chk("t5_done", rsp_cnt, r0 + 2);

        // reset while the core is running
        cfg_d[2] = 12;
        a0 = acc_cnt;
        bus.req_valid = 4'b0100;
        cyc = 0;
        while (acc_cnt == a0 && cyc < 100) begin
            tick(1);
            cyc++;
        end
        bus.req_valid = '0;
        tick(5);
        chk("t6_in_run", core_rst_n, 1'b1);
        r0 = rsp_cnt;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("t6_rsp_valid", bus.rsp_valid, 1'b0);
        chk("t6_core_rst_n", core_rst_n, 1'b0);
        chk("t6_core_w", core_w, '0);
        chk("t6_rsp_id", bus.rsp_id, '0);
        tick(20);
        chk("t6_no_rsp", rsp_cnt, r0);
        cfg_d[1] = 5;
        run(4'b0010, 1);
        chk("t6_after_id", rsp_log[rsp_log.size()-1], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
